// File: rtl/mult_control_param.sv
// mult_control_param: sequencer for a digit-serial shift-add multiplier.
// Walks DIGITS x DIGITS digit pairs (i fastest), drives the accumulator
// enable/clear and the digit and shift selects, and flags done/busy/err.
// Optional build macro MULT_CTRL_STALL_EN adds a 'stall' input that freezes
// the CALC sequence.
module mult_control_param #(
    parameter  int unsigned DIGITS  = 2,
    parameter  int unsigned DIGIT_W = 4,
    localparam int unsigned SEL_W   = ($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1,
    localparam int unsigned SHIFT_W = ($clog2(2*DIGITS-1) > 1) ? $clog2(2*DIGITS-1) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
`ifdef MULT_CTRL_STALL_EN
    input  logic               stall,
`endif
    output logic               done,
    output logic               busy,
    output logic               err,
    output logic               clk_ena,
    output logic               sclr_n,
    output logic [SEL_W-1:0]   a_sel,
    output logic [SEL_W-1:0]   b_sel,
    output logic [SHIFT_W-1:0] shift_sel,
    output logic [2:0]         state_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_CLEAR = 3'b001,
        S_CALC  = 3'b010,
        S_DONE  = 3'b011,
        S_ERR   = 3'b100
    } state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DIGITS - 1);

    // Elaboration-time sanity checks on the parameters
    if (DIGITS < 2) begin : g_digits_check
        $error("mult_control_param: DIGITS must be >= 2");
    end
    if (DIGIT_W < 1) begin : g_digit_w_check
        $error("mult_control_param: DIGIT_W must be >= 1");
    end

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   i_q, i_d;
    logic [SEL_W-1:0]   j_q, j_d;
    logic               stall_act;

`ifdef MULT_CTRL_STALL_EN
    assign stall_act = stall;
`else
    assign stall_act = 1'b0;
`endif

    // State and digit-index registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // Next-state and index sequencing; start anywhere in CLEAR/CALC aborts to ERR
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                i_d     = '0;
                j_d     = '0;
                state_d = start ? S_ERR : S_CALC;
            end
            S_CALC: begin
                if (start) begin
                    state_d = S_ERR;
                    i_d     = '0;
                    j_d     = '0;
                end else if (!stall_act) begin
                    if (i_q == LAST_IDX) begin
                        i_d = '0;
                        if (j_q == LAST_IDX) begin
                            j_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            j_d = j_q + SEL_W'(1);
                        end
                    end else begin
                        i_d = i_q + SEL_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = start ? S_CLEAR : S_IDLE;
            end
            S_ERR: begin
                if (start) state_d = S_CLEAR;
            end
            default: begin
                state_d = S_IDLE;
                i_d     = '0;
                j_d     = '0;
            end
        endcase
    end

    // Moore output decode; stall only gates the accumulator enable in CALC
    always_comb begin
        done      = 1'b0;
        busy      = 1'b0;
        err       = 1'b0;
        clk_ena   = 1'b0;
        sclr_n    = 1'b1;
        a_sel     = '0;
        b_sel     = '0;
        shift_sel = '0;
        case (state_q)
            S_CLEAR: begin
                busy    = 1'b1;
                clk_ena = 1'b1;
                sclr_n  = 1'b0;
            end
            S_CALC: begin
                busy      = 1'b1;
                clk_ena   = !stall_act;
                a_sel     = i_q;
                b_sel     = j_q;
                shift_sel = SHIFT_W'(i_q) + SHIFT_W'(j_q);
            end
            S_DONE: begin
                done = 1'b1;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_mult_control_param.sv
// Bench for mult_control_param: DIGITS=2 and DIGITS=4 instances, expected
// per-cycle outputs queued from a reference table and compared each cycle.
`timescale 1ns/1ps
module tb_mult_control_param;

    typedef struct packed {
        logic [2:0] st;
        logic       done;
        logic       busy;
        logic       err;
        logic       ce;
        logic       sclr;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sh;
    } obs_t;

    localparam logic [2:0] IDLE  = 3'b000;
    localparam logic [2:0] CLEAR = 3'b001;
    localparam logic [2:0] CALC  = 3'b010;
    localparam logic [2:0] DONE  = 3'b011;
    localparam logic [2:0] ERR   = 3'b100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic start2;
    logic start4;
`ifdef MULT_CTRL_STALL_EN
    logic stall2;
`endif

    logic       done2, busy2, err2, ce2, sclr2;
    logic [0:0] a_sel2, b_sel2;
    logic [1:0] shift_sel2;
    logic [2:0] st2;

    logic       done4, busy4, err4, ce4, sclr4;
    logic [1:0] a_sel4, b_sel4;
    logic [2:0] shift_sel4;
    logic [2:0] st4;

    mult_control_param #(.DIGITS(2), .DIGIT_W(4)) u_dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start2),
`ifdef MULT_CTRL_STALL_EN
        .stall     (stall2),
`endif
        .done      (done2),
        .busy      (busy2),
        .err       (err2),
        .clk_ena   (ce2),
        .sclr_n    (sclr2),
        .a_sel     (a_sel2),
        .b_sel     (b_sel2),
        .shift_sel (shift_sel2),
        .state_out (st2)
    );

    mult_control_param #(.DIGITS(4), .DIGIT_W(4)) u_dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start4),
`ifdef MULT_CTRL_STALL_EN
        .stall     (1'b0),
`endif
        .done      (done4),
        .busy      (busy4),
        .err       (err4),
        .clk_ena   (ce4),
        .sclr_n    (sclr4),
        .a_sel     (a_sel4),
        .b_sel     (b_sel4),
        .shift_sel (shift_sel4),
        .state_out (st4)
    );

    obs_t obs2, obs4;
    assign obs2 = {st2, done2, busy2, err2, ce2, sclr2, 8'(a_sel2), 8'(b_sel2), 8'(shift_sel2)};
    assign obs4 = {st4, done4, busy4, err4, ce4, sclr4, 8'(a_sel4), 8'(b_sel4), 8'(shift_sel4)};

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference output table per state
    function automatic obs_t mk(input logic [2:0] st, input int a, input int b, input logic ce_calc);
        obs_t o;
        o      = '0;
        o.st   = st;
        o.sclr = 1'b1;
        case (st)
            CLEAR: begin o.busy = 1'b1; o.ce = 1'b1; o.sclr = 1'b0; end
            CALC: begin
                o.busy = 1'b1;
                o.ce   = ce_calc;
                o.a    = 8'(a);
                o.b    = 8'(b);
                o.sh   = 8'(a + b);
            end
            DONE: o.done = 1'b1;
            ERR:  o.err  = 1'b1;
            default: begin end
        endcase
        return o;
    endfunction

    task automatic push(input logic [2:0] st);
        exp_q.push_back(mk(st, 0, 0, 1'b1));
    endtask

    task automatic push_calc(input int a, input int b, input logic ce);
        exp_q.push_back(mk(CALC, a, b, ce));
    endtask

    // One full operation: CLEAR, d*d CALC steps (A digit fastest), DONE
    task automatic push_run(input int d);
        push(CLEAR);
        for (int j = 0; j < d; j++)
            for (int i = 0; i < d; i++)
                push_calc(i, j, 1'b1);
        push(DONE);
    endtask

    // Drain the queue one cycle per entry, driving start/reset/stall per step
    task automatic play(input bit use4, input string tag, input int s0, input int s1,
                        input int rst_at, input int stall_from, input int stall_len);
        int   k;
        obs_t e, o;
        logic st;
        k = 0;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            st = (k == s0) || (k == s1);
            if (use4) start4 = st; else start2 = st;
            reset_n = (k == rst_at) ? 1'b0 : 1'b1;
`ifdef MULT_CTRL_STALL_EN
            stall2 = !use4 && (k >= stall_from) && (k < stall_from + stall_len);
`else
            if (stall_len != 0 && stall_from < 0) k = k;
`endif
            #1;
            o = use4 ? obs4 : obs2;
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s step %0d: observed %h expected %h", tag, k, o, e);
            end
            @(posedge clk);
            #1;
            k++;
        end
        start2  = 1'b0;
        start4  = 1'b0;
        reset_n = 1'b1;
`ifdef MULT_CTRL_STALL_EN
        stall2 = 1'b0;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start2  = 1'b0;
        start4  = 1'b0;
`ifdef MULT_CTRL_STALL_EN
        stall2  = 1'b0;
`endif
        // Reset values held over two clocks
        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            #1;
            checks++;
            assert (obs2 === mk(IDLE, 0, 0, 1'b1)) else begin
                errors++;
                $error("FAIL reset_d2: observed %h expected %h", obs2, mk(IDLE, 0, 0, 1'b1));
            end
            checks++;
            assert (obs4 === mk(IDLE, 0, 0, 1'b1)) else begin
                errors++;
                $error("FAIL reset_d4: observed %h expected %h", obs4, mk(IDLE, 0, 0, 1'b1));
            end
        end
        reset_n = 1'b1;

        // DIGITS=2 normal run: done in cycle 6, then IDLE
        push(IDLE); push_run(2); push(IDLE); push(IDLE);
        play(1'b0, "d2_run", 0, -1, -1, -1, 0);

        // DIGITS=4 normal run: 16 CALC cycles, done in cycle 18
        push(IDLE); push_run(4); push(IDLE);
        play(1'b1, "d4_run", 0, -1, -1, -1, 0);

        // start in 2nd CALC cycle aborts to ERR, which holds
        push(IDLE); push(CLEAR); push_calc(0, 0, 1'b1); push_calc(1, 0, 1'b1);
        push(ERR); push(ERR); push(ERR); push(ERR);
        play(1'b0, "abort", 0, 3, -1, -1, 0);

        // start from ERR recovers with a full normal run
        push(ERR); push_run(2); push(IDLE);
        play(1'b0, "recover", 0, -1, -1, -1, 0);

        // start in DONE restarts back-to-back
        push(IDLE); push_run(2); push_run(2); push(IDLE);
        play(1'b0, "b2b", 0, 6, -1, -1, 0);

        // reset during 3rd CALC cycle abandons the operation silently
        push(IDLE); push(CLEAR); push_calc(0, 0, 1'b1); push_calc(1, 0, 1'b1);
        push_calc(0, 1, 1'b1); push(IDLE); push(IDLE); push(IDLE);
        play(1'b0, "mid_reset", 0, -1, 4, -1, 0);

        // DIGITS=4 abort on the last CALC step
        push(IDLE); push(CLEAR);
        for (int n = 0; n < 16; n++) push_calc(n % 4, n / 4, 1'b1);
        push(ERR); push(ERR);
        play(1'b1, "d4_abort_last", 0, 17, -1, -1, 0);

`ifdef MULT_CTRL_STALL_EN
        // 3-cycle stall in 2nd CALC cycle: selects held, done in cycle 9
        push(IDLE); push(CLEAR); push_calc(0, 0, 1'b1);
        push_calc(1, 0, 1'b0); push_calc(1, 0, 1'b0); push_calc(1, 0, 1'b0);
        push_calc(1, 0, 1'b1); push_calc(0, 1, 1'b1); push_calc(1, 1, 1'b1);
        push(DONE); push(IDLE);
        play(1'b0, "stall", 0, -1, -1, 3, 3);

        // start beats stall in CALC; stall ignored in ERR
        push(IDLE); push(CLEAR); push_calc(0, 0, 1'b1); push_calc(1, 0, 1'b0);
        push(ERR); push(ERR);
        play(1'b0, "stall_start", 0, 3, -1, 3, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
